// File: rtl/md_pkg.sv
// Shared encodings and result constants for the iterative HI/LO multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 64;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = {MAX_WIDTH{1'b1}};
  localparam logic [MAX_WIDTH-1:0] OVF_REM   = {MAX_WIDTH{1'b0}};

  function automatic logic [MAX_WIDTH-1:0] most_negative(input int width);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module md_iter_step
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  div_mode_i,
  input  logic [DATA_WIDTH-1:0] acc_hi_i,
  input  logic [DATA_WIDTH-1:0] acc_lo_i,
  input  logic [DATA_WIDTH-1:0] opnd_i,
  output logic [DATA_WIDTH-1:0] acc_hi_o,
  output logic [DATA_WIDTH-1:0] acc_lo_o
);

  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   shifted_s;
  logic                  fits_s;
  logic [DATA_WIDTH-1:0] rem_sub_s;

  // The running remainder is always below the divisor, so the difference fits in DATA_WIDTH bits.
  assign sum_s     = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(DATA_WIDTH+1){1'b0}});
  assign shifted_s = {acc_hi_i, acc_lo_i[DATA_WIDTH-1]};
  assign fits_s    = (shifted_s >= {1'b0, opnd_i});
  assign rem_sub_s = shifted_s[DATA_WIDTH-1:0] - opnd_i;

  always_comb begin
    acc_hi_o = acc_hi_i;
    acc_lo_o = acc_lo_i;
    if (div_mode_i == MODE_DIV) begin
      acc_hi_o = fits_s ? rem_sub_s : shifted_s[DATA_WIDTH-1:0];
      acc_lo_o = {acc_lo_i[DATA_WIDTH-2:0], fits_s};
    end else begin
      acc_hi_o = sum_s[DATA_WIDTH:1];
      acc_lo_o = {sum_s[0], acc_lo_i[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// HI/LO multiply/divide sequencer: magnitude iteration over DATA_WIDTH cycles, then sign fix-up.
module mul_div_sequencer
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int                    CW         = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]         CNT_LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [MAX_WIDTH-1:0]  MOST_NEG_W = most_negative(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG   = MOST_NEG_W[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] DIV0_Q     = DIV0_QUOT[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] OVF_R      = OVF_REM[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ZERO       = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE        = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_WIDTH-1:0] ONE2     = {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] acc_hi_q;
  logic [DATA_WIDTH-1:0] acc_lo_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic                  div_q;
  logic                  neg_res_q;
  logic                  neg_rem_q;
  logic                  div0_q;
  logic                  ovf_q;

  op_e                   op_s;
  logic                  accept_s;
  logic                  signed_op_s;
  logic                  s1_neg_s;
  logic                  s2_neg_s;
  logic [DATA_WIDTH-1:0] acc_hi_d;
  logic [DATA_WIDTH-1:0] acc_lo_d;
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [DATA_WIDTH-1:0] fix_hi_s;
  logic [DATA_WIDTH-1:0] fix_lo_s;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  assign op_s        = op_e'(op);
  assign accept_s    = op_valid & ~busy_q & ~flush;
  assign stall       = op_valid & busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign signed_op_s = (op_s == OP_MULT) | (op_s == OP_DIV);
  assign s1_neg_s    = signed_op_s & src1[DATA_WIDTH-1];
  assign s2_neg_s    = signed_op_s & src2[DATA_WIDTH-1];

  md_iter_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .div_mode_i (div_q),
    .acc_hi_i   (acc_hi_q),
    .acc_lo_i   (acc_lo_q),
    .opnd_i     (opnd_q),
    .acc_hi_o   (acc_hi_d),
    .acc_lo_o   (acc_lo_d)
  );

  always_comb begin
    rd_data = ZERO;
    if (accept_s && op_s == OP_MFHI) begin
      rd_data = hi_q;
    end else if (accept_s && op_s == OP_MFLO) begin
      rd_data = lo_q;
    end else begin
      rd_data = ZERO;
    end
  end

  // Magnitude result from the iteration, sign-corrected; divide corner cases override it.
  always_comb begin
    prod_s   = {acc_hi_q, acc_lo_q};
    fix_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
    fix_lo_s = prod_s[DATA_WIDTH-1:0];
    if (div_q) begin
      fix_lo_s = cond_neg(acc_lo_q, neg_res_q);
      fix_hi_s = cond_neg(acc_hi_q, neg_rem_q);
      if (div0_q) begin
        fix_lo_s = DIV0_Q;
      end else if (ovf_q) begin
        fix_lo_s = MOST_NEG;
        fix_hi_s = OVF_R;
      end else begin
        fix_lo_s = cond_neg(acc_lo_q, neg_res_q);
      end
    end else begin
      if (neg_res_q) begin
        prod_s = ~{acc_hi_q, acc_lo_q} + ONE2;
      end else begin
        prod_s = {acc_hi_q, acc_lo_q};
      end
      fix_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      fix_lo_s = prod_s[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= ZERO;
      lo_q      <= ZERO;
      cnt_q     <= {CW{1'b0}};
      acc_hi_q  <= ZERO;
      acc_lo_q  <= ZERO;
      opnd_q    <= ZERO;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            case (op_s)
              OP_MULT, OP_MULTU: begin
                acc_hi_q  <= ZERO;
                acc_lo_q  <= cond_neg(src2, s2_neg_s);
                opnd_q    <= cond_neg(src1, s1_neg_s);
                div_q     <= MODE_MUL;
                neg_res_q <= s1_neg_s ^ s2_neg_s;
                neg_rem_q <= 1'b0;
                div0_q    <= 1'b0;
                ovf_q     <= 1'b0;
                cnt_q     <= {CW{1'b0}};
                busy_q    <= 1'b1;
                state_q   <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                acc_hi_q  <= ZERO;
                acc_lo_q  <= cond_neg(src1, s1_neg_s);
                opnd_q    <= cond_neg(src2, s2_neg_s);
                div_q     <= MODE_DIV;
                neg_res_q <= s1_neg_s ^ s2_neg_s;
                neg_rem_q <= s1_neg_s;
                div0_q    <= (src2 == ZERO);
                ovf_q     <= signed_op_s & (src1 == MOST_NEG) & (src2 == {DATA_WIDTH{1'b1}});
                cnt_q     <= {CW{1'b0}};
                busy_q    <= 1'b1;
                state_q   <= ST_RUN;
              end
              OP_MTHI: hi_q <= src1;
              OP_MTLO: lo_q <= src1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (!flush) begin
            hi_q   <= fix_hi_s;
            lo_q   <= fix_lo_s;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed plus randomized checks of the HI/LO sequencer against a plain-arithmetic reference.
module tb_mul_div_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] rd_data, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi, ref_lo;

  mul_div_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .stall(stall), .busy(busy), .rd_data(rd_data), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); return p; end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        else return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        else return {a % b, a / b};
      end
      3'd6: return {a, l};
      3'd7: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int edges, nbusy;
    @(negedge clk);
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    #1;
    chk("stall_idle", {63'd0, stall}, 64'd0);
    if (o == OP_MFHI) chk("mfhi_rd", {32'd0, rd_data}, {32'd0, ref_hi});
    if (o == OP_MFLO) chk("mflo_rd", {32'd0, rd_data}, {32'd0, ref_lo});
    e = model(o, a, b, ref_hi, ref_lo);
    @(negedge clk);
    op_valid = 1'b0;
    if (o >= 3'd4) begin
      chk("mx_busy", {63'd0, busy}, 64'd0);
    end else begin
      edges = 0; nbusy = 0;
      while (!done && edges < 100) begin
        if (busy) nbusy++;
        @(negedge clk);
        edges++;
      end
      chk("done_edge", 64'(edges), 64'd33);
      chk("busy_cycles", 64'(nbusy), 64'd33);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("done_pulse", {63'd0, done}, 64'd0);
    end
    ref_hi = e[63:32];
    ref_lo = e[31:0];
    chk("hilo", {hi, lo}, {ref_hi, ref_lo});
  endtask

  initial begin
    int cyc;
    logic seen_done;
    logic [31:0] corner [5];
    logic [31:0] ra, rb;
    corner[0] = 32'd0; corner[1] = 32'd1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

    rst = 1'b1; op_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0; flush = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_rd", {32'd0, rd_data}, 64'd0);
    rst = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(OP_DIVU, 32'd100, 32'd7);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_DIV, 32'd5, 32'd0);
    chk("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    do_op(OP_MTHI, 32'hCAFE_0001, 32'd0);
    do_op(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    do_op(OP_MFHI, 32'd0, 32'd0);
    do_op(OP_MFLO, 32'd0, 32'd0);

    // MULTU followed by a held MFLO: stalls through FIX, then reads the new LO
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULTU; src1 = 32'hFFFF_FFFF; src2 = 32'd3;
    @(negedge clk);
    op = OP_MFLO;
    {ref_hi, ref_lo} = model(OP_MULTU, 32'hFFFF_FFFF, 32'd3, ref_hi, ref_lo);
    cyc = 0;
    #1;
    while (stall && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("mflo_stall_cycles", 64'(cyc), 64'd33);
    chk("mflo_after_stall", {32'd0, rd_data}, {32'd0, ref_lo});
    chk("multu_hilo", {hi, lo}, {ref_hi, ref_lo});
    @(negedge clk);
    op_valid = 1'b0;

    // Flush while idle blocks acceptance of both reads and writes
    op_valid = 1'b1; op = OP_MFHI; flush = 1'b1;
    #1;
    chk("flush_idle_rd", {32'd0, rd_data}, 64'd0);
    op = OP_MTLO; src1 = 32'h1111_2222;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_mt", {32'd0, lo}, {32'd0, ref_lo});

    do_op(OP_MTHI, 32'h0000_1234, 32'd0);
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", {63'd0, seen_done}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'h0000_1234, ref_lo});

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("arst_no_done", {63'd0, seen_done}, 64'd0);
    do_op(OP_MULT, 32'd6, 32'd7);
    chk("mult_6x7", {hi, lo}, {32'd0, 32'd42});

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      do_op(3'($urandom_range(0, 7)), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
